tc0480scp_rom_responder: RTL

- ROM-side responder for the TC0480SCP BG tile fetch port. It services the toggle handshake: `rom_req` toggles and `rom_address` is held; the responder returns 64-bit `rom_data` and makes `rom_ack` equal to `rom_req`.
- Fetches each 64-bit tile row as two 32-bit beats from the SDRAM-side read port.
- Holds a small direct-mapped line buffer so that repeated tile rows within a scanline hit without a memory access.
- Sits between the TC0480SCP instance and the core's SDRAM arbiter.

---
 rtl/tc0480scp_pkg.sv | 17 +
 rtl/tc0480scp_rom_responder_if.sv | 30 +++
 rtl/tc0480scp_line_cache.sv | 50 +++++
 rtl/tc0480scp_rom_responder.sv | 126 ++++++++++++
 4 files changed

// File: rtl/tc0480scp_pkg.sv
// Shared types and widths for the TC0480SCP ROM-side responder.
package tc0480scp_pkg;

    localparam int unsigned ROM_BEATS = 2;
    localparam int unsigned BEAT_W    = 32;
    localparam int unsigned ROW_W     = ROM_BEATS * BEAT_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MREQ,
        BEAT0,
        BEAT1,
        FILL
    } rom_resp_state_t;

endpackage

// File: rtl/tc0480scp_rom_responder_if.sv
// Tile-fetch toggle handshake plus SDRAM read port seen by the ROM responder.
interface tc0480scp_rom_responder_if #(
    parameter int unsigned ADDR_W = 22
);
    import tc0480scp_pkg::*;

    logic [ADDR_W-1:0] rom_address;
    logic              rom_req;
    logic [ROW_W-1:0]  rom_data;
    logic              rom_ack;
    logic              flush;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [BEAT_W-1:0] mem_rdata;

    // Environment side: tile fetcher and SDRAM arbiter.
    modport master (
        output rom_address, rom_req, flush, mem_gnt, mem_rvalid, mem_rdata,
        input  rom_data, rom_ack, mem_addr, mem_req
    );

    // Responder side.
    modport slave (
        input  rom_address, rom_req, flush, mem_gnt, mem_rvalid, mem_rdata,
        output rom_data, rom_ack, mem_addr, mem_req
    );

endinterface

// File: rtl/tc0480scp_line_cache.sv
// Direct-mapped tile-row buffer: combinational read, one write port, bulk invalidate.
module tc0480scp_line_cache
    import tc0480scp_pkg::*;
#(
    parameter int unsigned LINES  = 4,
    parameter int unsigned ADDR_W = 22,
    localparam int unsigned IDX_W = $clog2(LINES),
    localparam int unsigned TAG_W = ADDR_W - 3 - IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [ROW_W-1:0] wr_data_i,
    input  logic             wr_valid_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_c_o,
    output logic [TAG_W-1:0] rd_tag_c_o,
    output logic [ROW_W-1:0] rd_data_c_o
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [ROW_W-1:0] data_q [LINES];

    // A flush in the same cycle as a write leaves that entry invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_c_o = valid_q[rd_idx_i];
    assign rd_tag_c_o   = tag_q[rd_idx_i];
    assign rd_data_c_o  = data_q[rd_idx_i];

endmodule

// File: rtl/tc0480scp_rom_responder.sv
// ROM responder for the TC0480SCP BG tile port: line-buffer lookup, two-beat
// SDRAM fill on miss, toggle acknowledge back to the tile fetcher.
module tc0480scp_rom_responder
    import tc0480scp_pkg::*;
#(
    parameter int unsigned ADDR_W = 22,
    parameter int unsigned LINES  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    tc0480scp_rom_responder_if.slave    bus
);

    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned LINE_W = ADDR_W - 3;
    localparam int unsigned TAG_W  = LINE_W - IDX_W;

    rom_resp_state_t   state_q;
    logic [LINE_W-1:0] line_q;
    logic [BEAT_W-1:0] lo_q;
    logic [BEAT_W-1:0] hi_q;
    logic              inval_q;
    logic              rom_ack_q;
    logic [ROW_W-1:0]  rom_data_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic              rd_valid_c;
    logic [TAG_W-1:0]  rd_tag_c;
    logic [ROW_W-1:0]  rd_data_c;
    logic              hit_c;
    logic              fill_c;
    logic              unused_c;

    assign fill_c   = (state_q == FILL);
    assign unused_c = ^bus.rom_address[2:0];

    tc0480scp_line_cache #(
        .LINES  (LINES),
        .ADDR_W (ADDR_W)
    ) u_cache (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (bus.flush),
        .we_i         (fill_c),
        .wr_idx_i     (line_q[IDX_W-1:0]),
        .wr_tag_i     (line_q[LINE_W-1:IDX_W]),
        .wr_data_i    ({hi_q, lo_q}),
        .wr_valid_i   (~inval_q),
        .rd_idx_i     (line_q[IDX_W-1:0]),
        .rd_valid_c_o (rd_valid_c),
        .rd_tag_c_o   (rd_tag_c),
        .rd_data_c_o  (rd_data_c)
    );

    // A flush landing on the lookup cycle must not return pre-flush data.
    assign hit_c = rd_valid_c && (rd_tag_c == line_q[LINE_W-1:IDX_W]) && !bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            line_q     <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            inval_q    <= 1'b0;
            rom_ack_q  <= 1'b0;
            rom_data_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.rom_req != rom_ack_q) begin
                        line_q  <= bus.rom_address[ADDR_W-1:3];
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    inval_q <= 1'b0;
                    if (hit_c) begin
                        rom_data_q <= rd_data_c;
                        rom_ack_q  <= bus.rom_req;
                        state_q    <= IDLE;
                    end else begin
                        mem_addr_q <= {line_q, 3'b000};
                        mem_req_q  <= 1'b1;
                        state_q    <= MREQ;
                    end
                end
                MREQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= BEAT0;
                    end
                end
                // Flushes during the beats keep the fetched row out of the buffer.
                BEAT0: begin
                    if (bus.flush) inval_q <= 1'b1;
                    if (bus.mem_rvalid) begin
                        lo_q    <= bus.mem_rdata;
                        state_q <= BEAT1;
                    end
                end
                BEAT1: begin
                    if (bus.flush) inval_q <= 1'b1;
                    if (bus.mem_rvalid) begin
                        hi_q    <= bus.mem_rdata;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    rom_data_q <= {hi_q, lo_q};
                    rom_ack_q  <= bus.rom_req;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rom_ack  = rom_ack_q;
    assign bus.rom_data = rom_data_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;

endmodule
